clm_inv_sequencer: RTL and testbench

//  Sequences one shared square unit and one shared multiplier to compute the GF(2^8) inverse x^254 on CLM-masked (8+d)-bit states.
//  - Fixed left-to-right square-and-multiply chain: 7 squarings interleaved with 6 multiplies by the input.
//  - Draws d fresh random bits per operation from a handshaked randomness source; each op refreshes its result.
//  - Sits between the SubBytes front end and the affine stage. The square/mult datapaths are external and purely combinational.

---
 rtl/clm_inv_sequencer.sv | 138 +++++++++++++
 tb/tb_clm_inv_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clm_inv_sequencer.sv
// clm_inv_sequencer
// Drives one shared squarer and one shared multiplier through the fixed
// square-and-multiply chain that turns a CLM-masked GF(2^8) operand x into
// x^254, its multiplicative inverse. The state is 8+d bits wide, so it may
// carry extra multiples of the field polynomial as a mask. The arithmetic
// units live outside this block and are purely combinational. Each chain
// step uses one fresh d-bit refresh word taken from a valid/ready source.
//
// Chain layout, with acc starting at x:
//   even op_idx -> acc = acc^2 (refreshed)
//   odd  op_idx -> acc = acc*x (refreshed)
// That gives x^2, x^3, x^6, x^7, ... x^127, x^254 over 13 steps.
module clm_inv_sequencer #(
  parameter int d     = 2,
  parameter int N_OPS = 13
) (
  input  logic           clk,
  input  logic           rst,
  // operand side (from the SubBytes front end)
  input  logic [8+d-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  // result side (towards the affine stage)
  output logic [8+d-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  // fresh randomness source
  input  logic [d-1:0]   rnd_in,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  // shared square unit
  output logic [8+d-1:0] sq_in,
  output logic [d-1:0]   sq_r,
  input  logic [8+d-1:0] sq_out,
  // shared multiplier
  output logic [8+d-1:0] mul_a,
  output logic [8+d-1:0] mul_b,
  output logic [d-1:0]   mul_r,
  input  logic [8+d-1:0] mul_out,
  output logic           busy
);

  localparam int W     = 8 + d;
  localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] op_idx;
  logic [W-1:0]     acc;
  logic [W-1:0]     x_reg;
  logic [W-1:0]     step_result;

  // The arithmetic units always see the current accumulator and the stored
  // operand. Outside RUN their results are simply never sampled.
  assign sq_in = acc;
  assign mul_a = acc;
  assign mul_b = x_reg;
  assign sq_r  = rnd_in;
  assign mul_r = rnd_in;

  // Even steps square the accumulator; odd steps multiply it by x.
  always_comb begin
    step_result = sq_out;
    if (op_idx[0]) begin
      step_result = mul_out;
    end
  end

  // Sequencer FSM: accept an operand, run the chain one step per valid
  // refresh word, then hold the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_idx    <= '0;
      acc       <= '0;
      x_reg     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      rnd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg     <= in_data;
            acc       <= in_data;
            op_idx    <= '0;
            state     <= RUN;
            in_ready  <= 1'b0;
            rnd_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end

        RUN: begin
          if (rnd_valid) begin
            acc <= step_result;
            if (op_idx == LAST_IDX) begin
              op_idx    <= '0;
              state     <= DONE;
              rnd_ready <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= step_result;
            end else begin
              op_idx <= op_idx + IDX_W'(1);
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          op_idx    <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          rnd_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clm_inv_sequencer.sv
// Testbench for clm_inv_sequencer
// The square and multiply units are modelled as masked GF(2^8) operators.
// Each one reduces its operands, computes in the field, and then re-masks the
// result with the refresh word times the field polynomial. Results are checked
// against an inverse that is found by brute-force search over the field.
module tb_clm_inv_sequencer;

  localparam int D = 2;
  localparam int W = 8 + D;
  localparam logic [W-1:0] POLY = W'(9'h11B);

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [D-1:0] rnd_in;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [W-1:0] sq_in;
  logic [D-1:0] sq_r;
  logic [W-1:0] sq_out;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [D-1:0] mul_r;
  logic [W-1:0] mul_out;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int hs_total = 0;

  clm_inv_sequencer #(.d(D), .N_OPS(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rnd_in   (rnd_in),
    .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready),
    .sq_in    (sq_in),
    .sq_r     (sq_r),
    .sq_out   (sq_out),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_r    (mul_r),
    .mul_out  (mul_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every randomness handshake the DUT performs.
  always @(posedge clk) begin
    if (rnd_valid && rnd_ready) hs_total <= hs_total + 1;
  end

  // Reduce a masked state to its field element.
  function automatic logic [7:0] reduce(input logic [W-1:0] a);
    logic [W-1:0] t;
    t = a;
    for (int i = W - 1; i >= 8; i--) begin
      if (t[i]) t = t ^ (POLY << (i - 8));
    end
    return t[7:0];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic carry;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      carry = aa[7];
      aa = aa << 1;
      if (carry) aa = aa ^ 8'h1B;
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Mask a field element by adding r(x) * P(x).
  function automatic logic [W-1:0] lift(input logic [7:0] v, input logic [D-1:0] r);
    logic [W-1:0] res;
    res = {{D{1'b0}}, v};
    for (int i = 0; i < D; i++) begin
      if (r[i]) res = res ^ (POLY << i);
    end
    return res;
  endfunction

  function automatic logic [7:0] inv_ref(input logic [7:0] v);
    logic [7:0] y;
    inv_ref = 8'h00;
    for (int k = 1; k < 256; k++) begin
      y = 8'(k);
      if (v != 8'h00 && gf_mul(v, y) == 8'h01) inv_ref = y;
    end
  endfunction

  assign sq_out  = lift(gf_mul(reduce(sq_in), reduce(sq_in)), sq_r);
  assign mul_out = lift(gf_mul(reduce(mul_a), reduce(mul_b)), mul_r);

  // Offer one operand and feed randomness until a result appears. The refresh
  // source can be stalled once, at a chosen step, or the run can be aborted by
  // a reset. On entry the DUT must be idle, and the time must be 1 time unit
  // after a rising edge.
  task automatic applyStimulus(input logic [W-1:0] x, input bit rnd_random,
                               input int stall_at, input int stall_len, input int abort_at,
                               output int latency, output logic [W-1:0] result,
                               output int consumed, output bit timed_out,
                               output bit frozen_ok);
    int hs_start, cyc, stalled, steps;
    logic [W-1:0] frozen_val;
    bit done;
    hs_start = hs_total;
    stalled = 0; timed_out = 0; frozen_ok = 1; done = 0;
    frozen_val = '0;
    latency = 0;
    in_data = x; in_valid = 1'b1; rnd_valid = 1'b1;
    rnd_in = rnd_random ? D'($urandom) : '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = W'($urandom);
    cyc = 1;
    while (!done) begin
      steps = hs_total - hs_start;
      if (out_valid) begin
        done = 1;
      end else if (cyc > 80) begin
        timed_out = 1; done = 1;
      end else if (abort_at >= 0 && steps == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        done = 1;
      end else begin
        rnd_in = rnd_random ? D'($urandom) : '0;
        if (steps == stall_at && stalled < stall_len) begin
          if (stalled == 0) frozen_val = sq_in;
          else if (sq_in !== frozen_val) frozen_ok = 0;
          rnd_valid = 1'b0;
          stalled++;
        end else begin
          if (stalled > 0 && stalled == stall_len && sq_in !== frozen_val && steps == stall_at) frozen_ok = 0;
          rnd_valid = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    latency = cyc;
    result = out_data;
    consumed = hs_total - hs_start;
    rnd_valid = 1'b1;
  endtask

  task automatic drainResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (rnd_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_rnd_ready got=%b want=0", rnd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (sq_in !== '0) begin bad++; $display("[TB] FAIL reset_acc got=%h want=0", sq_in); end
    total++; if (mul_b !== '0) begin bad++; $display("[TB] FAIL reset_x_reg got=%h want=0", mul_b); end
  endtask

  task automatic test_basic_inverse();
    int lat, cnt; logic [W-1:0] res; bit to, fz;
    applyStimulus(10'h053, 1'b0, -1, 0, -1, lat, res, cnt, to, fz);
    total++; if (to) begin bad++; $display("[TB] FAIL basic_timeout got=timeout want=result"); end
    total++; if (lat != 14) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=14", lat); end
    total++; if (reduce(res) !== 8'hCA) begin bad++; $display("[TB] FAIL basic_value got=%h want=ca", reduce(res)); end
    total++; if (cnt != 13) begin bad++; $display("[TB] FAIL basic_rnd_count got=%0d want=13", cnt); end
    total++; if (busy !== 1'b1 || rnd_ready !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_done_flags got=busy%b rr%b ir%b want=busy1 rr0 ir0", busy, rnd_ready, in_ready);
    end
    drainResult();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_drain got=ov%b ir%b busy%b want=ov0 ir1 busy0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_random_refresh();
    int lat, cnt; logic [W-1:0] res; bit to, fz;
    applyStimulus(10'h002, 1'b1, -1, 0, -1, lat, res, cnt, to, fz);
    total++; if (to) begin bad++; $display("[TB] FAIL refresh_timeout got=timeout want=result"); end
    total++; if (reduce(res) !== 8'h8D) begin bad++; $display("[TB] FAIL refresh_value got=%h want=8d", reduce(res)); end
    total++; if (cnt != 13) begin bad++; $display("[TB] FAIL refresh_rnd_count got=%0d want=13", cnt); end
    drainResult();
  endtask

  task automatic test_corners();
    int lat, cnt; logic [W-1:0] res; bit to, fz;
    applyStimulus(10'h000, 1'b1, -1, 0, -1, lat, res, cnt, to, fz);
    total++; if (to || reduce(res) !== 8'h00) begin bad++; $display("[TB] FAIL corner_zero got=%h want=00", reduce(res)); end
    drainResult();
    applyStimulus(10'h001, 1'b1, -1, 0, -1, lat, res, cnt, to, fz);
    total++; if (to || reduce(res) !== 8'h01) begin bad++; $display("[TB] FAIL corner_one got=%h want=01", reduce(res)); end
    drainResult();
  endtask

  task automatic test_stall();
    int lat, cnt; logic [W-1:0] res, x; bit to, fz;
    x = W'($urandom);
    applyStimulus(x, 1'b1, 4, 5, -1, lat, res, cnt, to, fz);
    total++; if (to) begin bad++; $display("[TB] FAIL stall_timeout got=timeout want=result"); end
    total++; if (lat != 19) begin bad++; $display("[TB] FAIL stall_latency got=%0d want=19", lat); end
    total++; if (!fz) begin bad++; $display("[TB] FAIL stall_frozen got=acc_moved want=acc_held"); end
    total++; if (reduce(res) !== inv_ref(reduce(x))) begin
      bad++; $display("[TB] FAIL stall_value got=%h want=%h", reduce(res), inv_ref(reduce(x)));
    end
    total++; if (cnt != 13) begin bad++; $display("[TB] FAIL stall_rnd_count got=%0d want=13", cnt); end
    drainResult();
  endtask

  task automatic test_backpressure();
    int lat, cnt, hs_before; logic [W-1:0] res, x; bit to, fz;
    x = W'($urandom);
    applyStimulus(x, 1'b1, -1, 0, -1, lat, res, cnt, to, fz);
    total++; if (to || reduce(res) !== inv_ref(reduce(x))) begin
      bad++; $display("[TB] FAIL bp_value got=%h want=%h", reduce(res), inv_ref(reduce(x)));
    end
    hs_before = hs_total;
    in_valid = 1'b1; in_data = W'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_data !== res) begin
        bad++; $display("[TB] FAIL bp_hold[%0d] got=ov%b %h want=ov1 %h", i, out_valid, out_data, res);
      end
      total++; if (in_ready !== 1'b0 || rnd_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL bp_ready[%0d] got=ir%b rr%b want=ir0 rr0", i, in_ready, rnd_ready);
      end
    end
    in_valid = 1'b0;
    total++; if (hs_total != hs_before) begin
      bad++; $display("[TB] FAIL bp_rnd_extra got=%0d want=0", hs_total - hs_before);
    end
    drainResult();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL bp_accept got=ov%b ir%b want=ov0 ir1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, cnt; logic [W-1:0] res, x; bit to, fz;
    applyStimulus(W'($urandom), 1'b1, -1, 0, 7, lat, res, cnt, to, fz);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rnd_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_flags got=ir%b ov%b busy%b rr%b want=ir1 ov0 busy0 rr0", in_ready, out_valid, busy, rnd_ready);
    end
    total++; if (sq_in !== '0) begin bad++; $display("[TB] FAIL abort_acc got=%h want=0", sq_in); end
    x = W'($urandom);
    applyStimulus(x, 1'b1, -1, 0, -1, lat, res, cnt, to, fz);
    total++; if (to || lat != 14 || reduce(res) !== inv_ref(reduce(x))) begin
      bad++; $display("[TB] FAIL abort_next got=%h lat=%0d want=%h lat=14", reduce(res), lat, inv_ref(reduce(x)));
    end
    drainResult();
  endtask

  task automatic test_back_to_back();
    int lat, cnt, st_at, st_len; logic [W-1:0] res, x; bit to, fz;
    for (int n = 0; n < 8; n++) begin
      x = W'($urandom);
      st_at = $urandom_range(0, 12);
      st_len = $urandom_range(0, 3);
      applyStimulus(x, 1'b1, st_at, st_len, -1, lat, res, cnt, to, fz);
      total++; if (to || reduce(res) !== inv_ref(reduce(x))) begin
        bad++; $display("[TB] FAIL b2b_value[%0d] got=%h want=%h", n, reduce(res), inv_ref(reduce(x)));
      end
      total++; if (lat != 14 + st_len) begin
        bad++; $display("[TB] FAIL b2b_latency[%0d] got=%0d want=%0d", n, lat, 14 + st_len);
      end
      total++; if (cnt != 13) begin bad++; $display("[TB] FAIL b2b_rnd_count[%0d] got=%0d want=13", n, cnt); end
      drainResult();
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    rnd_in = '0; rnd_valid = 1'b0;
    $display("[TB] starting clm_inv_sequencer tests");
    test_reset();
    test_basic_inverse();
    test_random_refresh();
    test_corners();
    test_stall();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
